// File: rtl/cam_pkg.sv
// Shared op codes and FSM state encoding for the associative CAM.
package cam_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_SEARCH = 2'b00,
        OP_INSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_FLUSH  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MATCH = 2'b01,
        EXEC  = 2'b10,
        RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/assoc_cam_if.sv
// Op/response bus of the associative CAM. Build option CAM_MASK_EN adds key_mask.
interface assoc_cam_if #(
    parameter int unsigned DATA_W = 7,
    parameter int unsigned DEPTH  = 16
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op_code;
    logic [DATA_W-1:0] key;
`ifdef CAM_MASK_EN
    logic [DATA_W-1:0] key_mask;
`endif
    logic              rsp_valid;
    logic              rsp_hit;
    logic [DEPTH-1:0]  rsp_onehot;
    logic [IDX_W-1:0]  rsp_index;
    logic              rsp_evict;
    logic [CNT_W-1:0]  count;
    logic              full;

`ifdef CAM_MASK_EN
    modport master (output op_valid, op_code, key, key_mask,
                    input  op_ready, rsp_valid, rsp_hit, rsp_onehot, rsp_index, rsp_evict, count, full);
    modport slave  (input  op_valid, op_code, key, key_mask,
                    output op_ready, rsp_valid, rsp_hit, rsp_onehot, rsp_index, rsp_evict, count, full);
`else
    modport master (output op_valid, op_code, key,
                    input  op_ready, rsp_valid, rsp_hit, rsp_onehot, rsp_index, rsp_evict, count, full);
    modport slave  (input  op_valid, op_code, key,
                    output op_ready, rsp_valid, rsp_hit, rsp_onehot, rsp_index, rsp_evict, count, full);
`endif

endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit encoder with an any-bit-set flag (combinational).
module cam_prio_enc #(
    parameter int unsigned DEPTH = 16
) (
    input  logic [DEPTH-1:0]         i_vec,
    output logic [$clog2(DEPTH)-1:0] o_index_c,
    output logic                     o_any_c
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        o_index_c = '0;
        o_any_c   = |i_vec;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_vec[i]) o_index_c = IDX_W'(i);
        end
    end

endmodule

// File: rtl/assoc_cam.sv
// Associative CAM with valid bits, search/insert/delete/flush, dedupe on insert,
// lowest-free allocation and round-robin eviction when full.
// Build option CAM_MASK_EN: per-op key_mask (don't-care bits) for SEARCH/DELETE.
module assoc_cam
    import cam_pkg::*;
#(
    parameter int unsigned DATA_W = 7,
    parameter int unsigned DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    assoc_cam_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    state_e            r_state;
    op_e               r_op;
    logic [DATA_W-1:0] r_key;
`ifdef CAM_MASK_EN
    logic [DATA_W-1:0] r_mask;
`endif
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_match;
    logic [IDX_W-1:0]  r_victim;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_ready;
    logic              r_rsp_valid;
    logic              r_rsp_hit;
    logic [DEPTH-1:0]  r_rsp_onehot;
    logic [IDX_W-1:0]  r_rsp_index;
    logic              r_rsp_evict;

    logic [DATA_W-1:0] w_cmp_mask;
    logic [DEPTH-1:0]  w_match;
    logic [DEPTH-1:0]  w_free_vec;
    logic [IDX_W-1:0]  w_hit_idx;
    logic              w_hit_any;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_free_any;
    logic [IDX_W-1:0]  w_ins_slot;
    logic [DEPTH-1:0]  w_ins_onehot;
    logic [CNT_W-1:0]  w_del_cnt;

    // Compare mask: INSERT dedupe is always exact.
    always_comb begin
        w_cmp_mask = '1;
`ifdef CAM_MASK_EN
        if (r_op != OP_INSERT) w_cmp_mask = r_mask;
`endif
    end

    // Per-entry compare; invalid entries never match.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = r_valid[i] & (((r_data[i] ^ r_key) & w_cmp_mask) == '0);
        end
    end

    assign w_free_vec = ~r_valid;

    cam_prio_enc #(.DEPTH(DEPTH)) u_hit_enc (
        .i_vec     (r_match),
        .o_index_c (w_hit_idx),
        .o_any_c   (w_hit_any)
    );

    cam_prio_enc #(.DEPTH(DEPTH)) u_free_enc (
        .i_vec     (w_free_vec),
        .o_index_c (w_free_idx),
        .o_any_c   (w_free_any)
    );

    // Insert target: existing slot, else lowest free, else victim.
    always_comb begin
        w_ins_slot   = w_hit_any ? w_hit_idx : (w_free_any ? w_free_idx : r_victim);
        w_ins_onehot = DEPTH'(1) << w_ins_slot;
    end

    // Number of entries a DELETE removes.
    always_comb begin
        w_del_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_del_cnt = w_del_cnt + CNT_W'(r_match[i]);
        end
    end

    // Op sequencer: IDLE -> MATCH -> EXEC -> RESP, all state and outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_op         <= OP_SEARCH;
            r_key        <= '0;
`ifdef CAM_MASK_EN
            r_mask       <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
            r_valid      <= '0;
            r_match      <= '0;
            r_victim     <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_ready      <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_hit    <= 1'b0;
            r_rsp_onehot <= '0;
            r_rsp_index  <= '0;
            r_rsp_evict  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.op_valid && r_ready) begin
                        r_op    <= op_e'(bus.op_code);
                        r_key   <= bus.key;
`ifdef CAM_MASK_EN
                        r_mask  <= bus.key_mask;
`endif
                        r_ready <= 1'b0;
                        r_state <= MATCH;
                    end
                end
                MATCH: begin
                    r_match <= w_match;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_evict <= 1'b0;
                    r_state     <= RESP;
                    case (r_op)
                        OP_SEARCH: begin
                            r_rsp_hit    <= w_hit_any;
                            r_rsp_onehot <= r_match;
                            r_rsp_index  <= w_hit_idx;
                        end
                        OP_INSERT: begin
                            r_rsp_hit    <= w_hit_any;
                            r_rsp_onehot <= w_ins_onehot;
                            r_rsp_index  <= w_ins_slot;
                            if (!w_hit_any) begin
                                r_data[w_ins_slot]  <= r_key;
                                r_valid[w_ins_slot] <= 1'b1;
                                if (w_free_any) begin
                                    r_count <= r_count + CNT_W'(1);
                                    r_full  <= (r_count + CNT_W'(1)) == CNT_W'(DEPTH);
                                end else begin
                                    r_rsp_evict <= 1'b1;
                                    r_victim    <= r_victim + IDX_W'(1);
                                end
                            end
                        end
                        OP_DELETE: begin
                            r_rsp_hit    <= w_hit_any;
                            r_rsp_onehot <= r_match;
                            r_rsp_index  <= w_hit_idx;
                            r_valid      <= r_valid & ~r_match;
                            r_count      <= r_count - w_del_cnt;
                            r_full       <= (r_count - w_del_cnt) == CNT_W'(DEPTH);
                        end
                        default: begin
                            r_rsp_hit    <= 1'b0;
                            r_rsp_onehot <= '0;
                            r_rsp_index  <= '0;
                            r_valid      <= '0;
                            r_count      <= '0;
                            r_full       <= 1'b0;
                            r_victim     <= '0;
                        end
                    endcase
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready   = r_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_hit    = r_rsp_hit;
    assign bus.rsp_onehot = r_rsp_onehot;
    assign bus.rsp_index  = r_rsp_index;
    assign bus.rsp_evict  = r_rsp_evict;
    assign bus.count      = r_count;
    assign bus.full       = r_full;

endmodule

// File: tb/tb_assoc_cam.sv
// Directed bench for assoc_cam (default 7x16). Covers CAM_MASK_EN when defined.
module tb_assoc_cam;
    import cam_pkg::*;

    localparam int unsigned DATA_W = 7;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    assoc_cam_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    assoc_cam #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic              g_hit;
    logic              g_evict;
    logic [DEPTH-1:0]  g_onehot;
    logic [IDX_W-1:0]  g_idx;
    logic [CNT_W-1:0]  g_count;
    logic              g_full;
    logic              g_rdy_busy;
    logic [DATA_W-1:0] g_mask;
    int                g_lat;

    // Issue one op, wait for its response and capture the response fields.
    task automatic do_op(input op_e code, input logic [DATA_W-1:0] k, input logic [DATA_W-1:0] m);
        int n;
        @(negedge clk);
        n = 0;
        while (bus.op_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.op_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL op_ready_timeout: op_ready=%b required 1", bus.op_ready);
        end
        g_mask       = m;
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.key      = k;
`ifdef CAM_MASK_EN
        bus.key_mask = m;
`endif
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.key      = ~k;
        n = 0;
        g_rdy_busy = 1'b0;
        do begin
            @(negedge clk);
            n++;
            g_rdy_busy = g_rdy_busy | bus.op_ready;
        end while (bus.rsp_valid !== 1'b1 && n < 10);
        if (bus.rsp_valid !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", bus.rsp_valid);
        end
        g_lat    = n;
        g_hit    = bus.rsp_hit;
        g_evict  = bus.rsp_evict;
        g_onehot = bus.rsp_onehot;
        g_idx    = bus.rsp_index;
        g_count  = bus.count;
        g_full   = bus.full;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_code  = 2'b00;
        bus.key      = '0;
`ifdef CAM_MASK_EN
        bus.key_mask = '1;
`endif
        repeat (3) @(negedge clk);
        n_checks++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.op_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.count !== 5'd0 || bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_count: got %0d/%b want 0/0", bus.count, bus.full); end
        n_checks++; if (bus.rsp_onehot !== 16'h0 || bus.rsp_index !== 4'd0 || bus.rsp_hit !== 1'b0) begin n_fail++; $display("FAIL rst_rsp: got %h/%0d/%b want 0/0/0", bus.rsp_onehot, bus.rsp_index, bus.rsp_hit); end
        rst_n = 1'b1;
        do_op(OP_SEARCH, 7'h00, 7'h7F);
        n_checks++; if (g_hit !== 1'b0) begin n_fail++; $display("FAIL rst_search_hit: got %b want 0", g_hit); end
        n_checks++; if (g_lat !== 3) begin n_fail++; $display("FAIL rsp_latency: got %0d want 3", g_lat); end
        n_checks++; if (g_rdy_busy !== 1'b0) begin n_fail++; $display("FAIL ready_while_busy: got %b want 0", g_rdy_busy); end
        n_checks++; if (g_count !== 5'd0) begin n_fail++; $display("FAIL rst_search_count: got %0d want 0", g_count); end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_pulse_width: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_rsp: got %b want 1", bus.op_ready); end
    endtask

    task automatic test_insert_dedupe();
        do_op(OP_INSERT, 7'h11, 7'h7F);
        n_checks++; if (g_idx !== 4'd0 || g_hit !== 1'b0 || g_evict !== 1'b0) begin n_fail++; $display("FAIL ins_11: got idx=%0d hit=%b ev=%b want 0/0/0", g_idx, g_hit, g_evict); end
        do_op(OP_INSERT, 7'h22, 7'h7F);
        n_checks++; if (g_idx !== 4'd1 || g_onehot !== 16'h0002) begin n_fail++; $display("FAIL ins_22: got idx=%0d oh=%h want 1/0002", g_idx, g_onehot); end
        do_op(OP_INSERT, 7'h11, 7'h7F);
        n_checks++; if (g_hit !== 1'b1 || g_idx !== 4'd0 || g_onehot !== 16'h0001) begin n_fail++; $display("FAIL ins_dup: got hit=%b idx=%0d oh=%h want 1/0/0001", g_hit, g_idx, g_onehot); end
        n_checks++; if (g_count !== 5'd2) begin n_fail++; $display("FAIL ins_count: got %0d want 2", g_count); end
    endtask

    task automatic test_fill_evict();
        for (int i = 0; i < 14; i++) begin
            do_op(OP_INSERT, 7'(8'h30 + i), 7'h7F);
            n_checks++; if (g_idx !== 4'(i + 2) || g_evict !== 1'b0) begin n_fail++; $display("FAIL fill_idx: got %0d ev=%b want %0d/0", g_idx, g_evict, i + 2); end
        end
        n_checks++; if (g_count !== 5'd16 || g_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0d/%b want 16/1", g_count, g_full); end
        do_op(OP_INSERT, 7'h7F, 7'h7F);
        n_checks++; if (g_evict !== 1'b1 || g_idx !== 4'd0 || g_hit !== 1'b0 || g_onehot !== 16'h0001) begin n_fail++; $display("FAIL evict_0: got ev=%b idx=%0d hit=%b oh=%h want 1/0/0/0001", g_evict, g_idx, g_hit, g_onehot); end
        n_checks++; if (g_count !== 5'd16 || g_full !== 1'b1) begin n_fail++; $display("FAIL evict_count: got %0d/%b want 16/1", g_count, g_full); end
        do_op(OP_INSERT, 7'h7E, 7'h7F);
        n_checks++; if (g_evict !== 1'b1 || g_idx !== 4'd1) begin n_fail++; $display("FAIL evict_1: got ev=%b idx=%0d want 1/1", g_evict, g_idx); end
        do_op(OP_SEARCH, 7'h11, 7'h7F);
        n_checks++; if (g_hit !== 1'b0 || g_onehot !== 16'h0) begin n_fail++; $display("FAIL search_evicted: got hit=%b oh=%h want 0/0000", g_hit, g_onehot); end
        do_op(OP_SEARCH, 7'h30, 7'h7F);
        n_checks++; if (g_hit !== 1'b1 || g_idx !== 4'd2 || g_onehot !== 16'h0004) begin n_fail++; $display("FAIL search_30: got hit=%b idx=%0d oh=%h want 1/2/0004", g_hit, g_idx, g_onehot); end
        do_op(OP_INSERT, 7'h30, 7'h7F);
        n_checks++; if (g_hit !== 1'b1 || g_evict !== 1'b0 || g_idx !== 4'd2) begin n_fail++; $display("FAIL dup_when_full: got hit=%b ev=%b idx=%0d want 1/0/2", g_hit, g_evict, g_idx); end
    endtask

    task automatic test_delete_flush();
        do_op(OP_DELETE, 7'h35, 7'h7F);
        n_checks++; if (g_hit !== 1'b1 || g_idx !== 4'd7 || g_onehot !== 16'h0080) begin n_fail++; $display("FAIL del_35: got hit=%b idx=%0d oh=%h want 1/7/0080", g_hit, g_idx, g_onehot); end
        n_checks++; if (g_count !== 5'd15 || g_full !== 1'b0) begin n_fail++; $display("FAIL del_count: got %0d/%b want 15/0", g_count, g_full); end
        do_op(OP_INSERT, 7'h22, 7'h7F);
        n_checks++; if (g_idx !== 4'd7 || g_evict !== 1'b0 || g_count !== 5'd16) begin n_fail++; $display("FAIL ins_freed: got idx=%0d ev=%b cnt=%0d want 7/0/16", g_idx, g_evict, g_count); end
        do_op(OP_DELETE, 7'h22, 7'h7F);
        n_checks++; if (g_hit !== 1'b1 || g_count !== 5'd15) begin n_fail++; $display("FAIL del_22: got hit=%b cnt=%0d want 1/15", g_hit, g_count); end
        do_op(OP_SEARCH, 7'h22, 7'h7F);
        n_checks++; if (g_hit !== 1'b0 || g_onehot !== 16'h0) begin n_fail++; $display("FAIL stale_search: got hit=%b oh=%h want 0/0000", g_hit, g_onehot); end
        do_op(OP_DELETE, 7'h22, 7'h7F);
        n_checks++; if (g_hit !== 1'b0 || g_count !== 5'd15) begin n_fail++; $display("FAIL del_miss: got hit=%b cnt=%0d want 0/15", g_hit, g_count); end
        do_op(OP_FLUSH, 7'h00, 7'h7F);
        n_checks++; if (g_hit !== 1'b0 || g_onehot !== 16'h0 || g_count !== 5'd0 || g_full !== 1'b0) begin n_fail++; $display("FAIL flush: got hit=%b oh=%h cnt=%0d full=%b want 0/0000/0/0", g_hit, g_onehot, g_count, g_full); end
        do_op(OP_SEARCH, 7'h7F, 7'h7F);
        n_checks++; if (g_hit !== 1'b0) begin n_fail++; $display("FAIL search_after_flush: got %b want 0", g_hit); end
    endtask

    task automatic test_victim_after_flush();
        for (int i = 0; i < 16; i++) do_op(OP_INSERT, 7'(8'h40 + i), 7'h7F);
        n_checks++; if (g_idx !== 4'd15 || g_full !== 1'b1) begin n_fail++; $display("FAIL refill: got idx=%0d full=%b want 15/1", g_idx, g_full); end
        do_op(OP_INSERT, 7'h01, 7'h7F);
        n_checks++; if (g_evict !== 1'b1 || g_idx !== 4'd0) begin n_fail++; $display("FAIL victim_reset: got ev=%b idx=%0d want 1/0", g_evict, g_idx); end
        do_op(OP_FLUSH, 7'h00, 7'h7F);
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        do_op(OP_INSERT, 7'h55, 7'h7F);
        n_checks++; if (g_idx !== 4'd0 || g_count !== 5'd1) begin n_fail++; $display("FAIL pre_abort_ins: got idx=%0d cnt=%0d want 0/1", g_idx, g_count); end
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_code  = OP_SEARCH;
        bus.key      = 7'h55;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.op_ready !== 1'b1 || bus.count !== 5'd0) begin n_fail++; $display("FAIL abort_state: got rdy=%b cnt=%0d want 1/0", bus.op_ready, bus.count); end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_rsp: got rsp_valid seen=%b want 0", seen); end
        n_checks++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", bus.op_ready); end
        do_op(OP_SEARCH, 7'h55, 7'h7F);
        n_checks++; if (g_hit !== 1'b0 || g_count !== 5'd0) begin n_fail++; $display("FAIL abort_search: got hit=%b cnt=%0d want 0/0", g_hit, g_count); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_op(OP_INSERT, 7'h11, 7'h7F);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_code  = OP_SEARCH;
        bus.key      = 7'h11;
        @(posedge clk);
        #1;
        bus.op_code  = OP_INSERT;
        bus.key      = 7'h44;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.rsp_valid !== 1'b1 && n < 10);
        bus.op_valid = 1'b0;
        n_checks++; if (bus.rsp_hit !== 1'b1 || bus.rsp_index !== 4'd0 || n !== 3) begin n_fail++; $display("FAIL busy_search: got hit=%b idx=%0d lat=%0d want 1/0/3", bus.rsp_hit, bus.rsp_index, n); end
        repeat (3) @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_hit !== 1'b1 || bus.rsp_onehot !== 16'h0001) begin n_fail++; $display("FAIL rsp_hold: got v=%b hit=%b oh=%h want 0/1/0001", bus.rsp_valid, bus.rsp_hit, bus.rsp_onehot); end
        n_checks++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL busy_ignored: got cnt=%0d want 1", bus.count); end
        do_op(OP_SEARCH, 7'h44, 7'h7F);
        n_checks++; if (g_hit !== 1'b0) begin n_fail++; $display("FAIL busy_insert_dropped: got hit=%b want 0", g_hit); end
    endtask

`ifdef CAM_MASK_EN
    task automatic test_mask();
        do_op(OP_FLUSH, 7'h00, 7'h7F);
        do_op(OP_INSERT, 7'h10, 7'h7C);
        do_op(OP_INSERT, 7'h13, 7'h7C);
        n_checks++; if (g_idx !== 4'd1 || g_hit !== 1'b0) begin n_fail++; $display("FAIL mask_ins_exact: got idx=%0d hit=%b want 1/0", g_idx, g_hit); end
        do_op(OP_SEARCH, 7'h10, 7'h7C);
        n_checks++; if (g_onehot !== 16'h0003 || g_idx !== 4'd0 || g_hit !== 1'b1) begin n_fail++; $display("FAIL mask_search: got oh=%h idx=%0d hit=%b want 0003/0/1", g_onehot, g_idx, g_hit); end
        do_op(OP_INSERT, 7'h12, 7'h7C);
        n_checks++; if (g_idx !== 4'd2 || g_hit !== 1'b0 || g_count !== 5'd3) begin n_fail++; $display("FAIL mask_ins_12: got idx=%0d hit=%b cnt=%0d want 2/0/3", g_idx, g_hit, g_count); end
        do_op(OP_DELETE, 7'h10, 7'h7C);
        n_checks++; if (g_onehot !== 16'h0007 || g_count !== 5'd0) begin n_fail++; $display("FAIL mask_delete: got oh=%h cnt=%0d want 0007/0", g_onehot, g_count); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_insert_dedupe();
        test_fill_evict();
        test_delete_flush();
        test_victim_after_flush();
        test_reset_mid_op();
        test_back_to_back();
`ifdef CAM_MASK_EN
        test_mask();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
